// File: rtl/add_sched_pkg.sv
// Shared definitions for the ADD job scheduler: FSM states and the ADD job-word layout.
package add_sched_pkg;

  localparam int CMD_INFO_W = 128;
  localparam int CMD_ADDR_W = 16;
  localparam int CMD_IDX_W  = 16;

  localparam int ADD0_LSB = 0;
  localparam int ADD1_LSB = CMD_ADDR_W;
  localparam int SUM_LSB  = 2 * CMD_ADDR_W;
  localparam int NUM_LSB  = 3 * CMD_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RUN,
    DRAIN,
    ABORT
  } schedState_t;

  function automatic logic [CMD_IDX_W-1:0] getNum(input logic [CMD_INFO_W-1:0] info);
    return info[NUM_LSB +: CMD_IDX_W];
  endfunction

endpackage

// File: rtl/add_cmd_fifo.sv
// Synchronous command FIFO with flush; full is registered from the next occupancy.
module add_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      countNext;
  logic             doPush, doPop;

  // Flush drops a same-cycle push; full blocks a push even if a pop happens this cycle.
  assign doPush = push & ~full & ~flush;
  assign doPop  = pop & ~empty & ~flush;
  assign empty  = (count == '0);
  assign rdData = mem[rdPtr];

  always_comb begin
    if (flush) countNext = '0;
    else       countNext = count + (AW+1)'(doPush) - (AW+1)'(doPop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      count <= countNext;
      full  <= (countNext == FULL_CNT);
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + AW'(1);
        if (doPop)  rdPtr <= rdPtr + AW'(1);
      end
    end
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/add_sched.sv
// ADD job scheduler: queues CCU jobs, issues them one at a time to ADD, counts Sum writes to detect completion.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int ADDISA_WIDTH = CMD_INFO_W,
  parameter int ADDR_WIDTH   = CMD_ADDR_W,
  parameter int IDX_WIDTH    = CMD_IDX_W,
  parameter int QDEPTH       = 4,
  parameter int DONE_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       CCUADS_CmdVld,
  output logic                       ADSCCU_CmdRdy,
  input  logic [ADDISA_WIDTH-1:0]    CCUADS_CmdInfo,
  input  logic                       CCUADS_Flush,
  output logic                       ADSADD_CfgVld,
  input  logic                       ADDADS_CfgRdy,
  output logic [ADDISA_WIDTH-1:0]    ADSADD_CfgInfo,
  input  logic                       ADDGLB_SumWrDatVld,
  input  logic                       GLBADD_SumWrDatRdy,
  output logic                       ADSCCU_JobDone,
  output logic [DONE_WIDTH-1:0]      ADSCCU_DoneCnt,
  output logic                       ADSCCU_Busy,
  output logic [$clog2(QDEPTH):0]    ADSCCU_QCnt
);

  schedState_t             state, stateNext;
  logic [ADDISA_WIDTH-1:0] jobInfo, headInfo;
  logic [IDX_WIDTH-1:0]    jobNum, headNum;
  logic [IDX_WIDTH:0]      wrCnt, wrCntInc;
  logic [DONE_WIDTH-1:0]   doneCnt;
  logic                    jobDone, doneEvt, pop, wrHs, fifoFull, fifoEmpty, cfgVld;

  add_cmd_fifo #(.DEPTH(QDEPTH), .WIDTH(ADDISA_WIDTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (CCUADS_CmdVld),
    .pop    (pop),
    .flush  (CCUADS_Flush),
    .wrData (CCUADS_CmdInfo),
    .rdData (headInfo),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (ADSCCU_QCnt)
  );

  assign headNum  = headInfo[3*ADDR_WIDTH +: IDX_WIDTH];
  assign jobNum   = jobInfo[3*ADDR_WIDTH +: IDX_WIDTH];
  assign wrHs     = ADDGLB_SumWrDatVld & GLBADD_SumWrDatRdy;
  assign wrCntInc = wrCnt + (IDX_WIDTH+1)'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    doneEvt   = 1'b0;
    cfgVld    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!CCUADS_Flush && !fifoEmpty) begin
          pop = 1'b1;
          if (headNum == '0) doneEvt   = 1'b1;
          else               stateNext = ISSUE;
        end
      end
      ISSUE: begin
        cfgVld = ~CCUADS_Flush;
        if (CCUADS_Flush)       stateNext = IDLE;
        else if (ADDADS_CfgRdy) stateNext = RUN;
      end
      RUN: begin
        if (CCUADS_Flush)                                stateNext = ABORT;
        else if (wrHs && wrCntInc == {1'b0, jobNum})     stateNext = DRAIN;
      end
      DRAIN: begin
        if (CCUADS_Flush) stateNext = ABORT;
        else if (ADDADS_CfgRdy) begin
          doneEvt   = 1'b1;
          stateNext = IDLE;
        end
      end
      ABORT: begin
        // An already-idle ADD would treat a pulse as a new job, so only abort a busy one.
        cfgVld    = ~ADDADS_CfgRdy;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      jobInfo <= '0;
      wrCnt   <= '0;
      jobDone <= 1'b0;
      doneCnt <= '0;
    end else begin
      state   <= stateNext;
      jobDone <= doneEvt;
      if (CCUADS_Flush) doneCnt <= '0;
      else if (doneEvt) doneCnt <= doneCnt + DONE_WIDTH'(1);
      if (pop) jobInfo <= headInfo;
      if (state == ISSUE)           wrCnt <= '0;
      else if (state == RUN && wrHs) wrCnt <= wrCntInc;
    end
  end

  assign ADSCCU_CmdRdy  = ~fifoFull;
  assign ADSADD_CfgVld  = cfgVld;
  assign ADSADD_CfgInfo = jobInfo;
  assign ADSCCU_JobDone = jobDone;
  assign ADSCCU_DoneCnt = doneCnt;
  assign ADSCCU_Busy    = (state != IDLE) | ~fifoEmpty;

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched: scoreboard queues of issued/completed jobs checked by a negedge monitor.
module tb_add_sched;

  localparam int AW = 128;
  localparam int A  = 16;
  localparam int IW = 16;
  localparam int QD = 4;
  localparam int DW = 8;
  localparam int QW = $clog2(QD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          CCUADS_CmdVld, ADSCCU_CmdRdy, CCUADS_Flush;
  logic [AW-1:0] CCUADS_CmdInfo, ADSADD_CfgInfo;
  logic          ADSADD_CfgVld, ADDADS_CfgRdy;
  logic          ADDGLB_SumWrDatVld, GLBADD_SumWrDatRdy;
  logic          ADSCCU_JobDone, ADSCCU_Busy;
  logic [DW-1:0] ADSCCU_DoneCnt;
  logic [QW-1:0] ADSCCU_QCnt;

  always #5 clk = ~clk;

  add_sched #(.ADDISA_WIDTH(AW), .ADDR_WIDTH(A), .IDX_WIDTH(IW), .QDEPTH(QD), .DONE_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .CCUADS_CmdVld      (CCUADS_CmdVld),
    .ADSCCU_CmdRdy      (ADSCCU_CmdRdy),
    .CCUADS_CmdInfo     (CCUADS_CmdInfo),
    .CCUADS_Flush       (CCUADS_Flush),
    .ADSADD_CfgVld      (ADSADD_CfgVld),
    .ADDADS_CfgRdy      (ADDADS_CfgRdy),
    .ADSADD_CfgInfo     (ADSADD_CfgInfo),
    .ADDGLB_SumWrDatVld (ADDGLB_SumWrDatVld),
    .GLBADD_SumWrDatRdy (GLBADD_SumWrDatRdy),
    .ADSCCU_JobDone     (ADSCCU_JobDone),
    .ADSCCU_DoneCnt     (ADSCCU_DoneCnt),
    .ADSCCU_Busy        (ADSCCU_Busy),
    .ADSCCU_QCnt        (ADSCCU_QCnt)
  );

  int            total = 0;
  int            passed = 0;
  int            failed = 0;
  int            issueSeen = 0;
  int            doneSeen = 0;
  logic [DW-1:0] expDoneCnt = '0;
  logic [AW-1:0] expIssue[$];
  logic [AW-1:0] expDone[$];

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] mkJob(input int id, input int num);
    logic [AW-1:0] j;
    j = '0;
    j[0 +: A]     = A'(16'h0100 + id);
    j[A +: A]     = A'(16'h4000 + id);
    j[2*A +: A]   = A'(16'h8000 + id);
    j[3*A +: IW]  = IW'(num);
    return j;
  endfunction

  function automatic int numOf(input logic [AW-1:0] job);
    return int'(job[3*A +: IW]);
  endfunction

  // Scoreboard monitor: every Cfg handshake and every JobDone must match the next expected job.
  always @(negedge clk) begin
    if (!rst) begin
      if (ADSADD_CfgVld && ADDADS_CfgRdy) begin
        issueSeen++;
        if (expIssue.size() == 0) check("issue expected", AW'(expIssue.size()), AW'(1));
        else                      check("issue info", ADSADD_CfgInfo, expIssue.pop_front());
      end
      if (ADSCCU_JobDone) begin
        doneSeen++;
        expDoneCnt++;
        if (expDone.size() == 0) check("done expected", AW'(expDone.size()), AW'(1));
        else                     check("done order", ADSADD_CfgInfo, expDone.pop_front());
        check("done count", AW'(ADSCCU_DoneCnt), AW'(expDoneCnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearScoreboard();
    expIssue.delete();
    expDone.delete();
    expDoneCnt = '0;
  endtask

  task automatic pushJob(input logic [AW-1:0] job);
    int n = 0;
    CCUADS_CmdVld  = 1'b1;
    CCUADS_CmdInfo = job;
    @(negedge clk);
    while (!ADSCCU_CmdRdy && n < 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("push accepted", AW'(ADSCCU_CmdRdy), AW'(1));
    tick();
    CCUADS_CmdVld = 1'b0;
    expDone.push_back(job);
    if (numOf(job) != 0) expIssue.push_back(job);
  endtask

  // Raises CfgRdy and waits for CfgVld; returns mid-cycle with the handshake due at the next edge.
  task automatic waitIssue();
    int n = 0;
    ADDADS_CfgRdy = 1'b1;
    @(negedge clk);
    while (!ADSADD_CfgVld && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("issue seen", AW'(ADSADD_CfgVld), AW'(1));
  endtask

  task automatic oneWrite();
    ADDGLB_SumWrDatVld = 1'b1;
    GLBADD_SumWrDatRdy = 1'b1;
    tick();
    ADDGLB_SumWrDatVld = 1'b0;
    GLBADD_SumWrDatRdy = 1'b0;
  endtask

  task automatic serveJob(input int lat, input bit earlyRdy);
    int num;
    int doneBase;
    doneBase = doneSeen;
    waitIssue();
    num = numOf(ADSADD_CfgInfo);
    tick();
    ADDADS_CfgRdy = 1'b0;
    for (int i = 0; i < num; i++) begin
      if (i == 0) begin
        ADDGLB_SumWrDatVld = 1'b1;
        GLBADD_SumWrDatRdy = 1'b0;
        tick();
      end
      if (earlyRdy && i == num - 1) begin
        ADDADS_CfgRdy = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("no done before last write", AW'(doneSeen), AW'(doneBase));
        check("busy before last write", AW'(ADSCCU_Busy), AW'(1));
      end
      oneWrite();
      GLBADD_SumWrDatRdy = 1'b1;
      tick();
      GLBADD_SumWrDatRdy = 1'b0;
    end
    repeat (lat) tick();
    ADDADS_CfgRdy = 1'b1;
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (doneSeen < target && n < 300) begin
      tick();
      n++;
    end
    check("jobs completed", AW'(doneSeen), AW'(target));
  endtask

  initial begin
    int base;
    rst = 1'b1;
    CCUADS_CmdVld = 1'b0;
    CCUADS_CmdInfo = '0;
    CCUADS_Flush = 1'b0;
    ADDADS_CfgRdy = 1'b1;
    ADDGLB_SumWrDatVld = 1'b0;
    GLBADD_SumWrDatRdy = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset CmdRdy", AW'(ADSCCU_CmdRdy), AW'(1));
    check("reset CfgVld", AW'(ADSADD_CfgVld), AW'(0));
    check("reset CfgInfo", ADSADD_CfgInfo, AW'(0));
    check("reset JobDone", AW'(ADSCCU_JobDone), AW'(0));
    check("reset DoneCnt", AW'(ADSCCU_DoneCnt), AW'(0));
    check("reset Busy", AW'(ADSCCU_Busy), AW'(0));
    check("reset QCnt", AW'(ADSCCU_QCnt), AW'(0));
    tick();
    rst = 1'b0;
    tick();

    // 1: single Num=3 job, CfgRdy raised early to prove completion waits for the write count.
    pushJob(mkJob(1, 3));
    serveJob(2, 1'b1);
    waitDone(1);
    @(negedge clk);
    check("t1 issues", AW'(issueSeen), AW'(1));
    check("t1 DoneCnt", AW'(ADSCCU_DoneCnt), AW'(1));
    check("t1 Busy idle", AW'(ADSCCU_Busy), AW'(0));
    tick();

    // 2: five jobs into a stalled ADD fill the FIFO; a sixth push is refused.
    ADDADS_CfgRdy = 1'b0;
    pushJob(mkJob(10, 1));
    pushJob(mkJob(11, 2));
    pushJob(mkJob(12, 1));
    pushJob(mkJob(13, 3));
    pushJob(mkJob(14, 2));
    @(negedge clk);
    check("t2 CmdRdy full", AW'(ADSCCU_CmdRdy), AW'(0));
    check("t2 QCnt full", AW'(ADSCCU_QCnt), AW'(4));
    tick();
    CCUADS_CmdVld = 1'b1;
    CCUADS_CmdInfo = mkJob(99, 1);
    tick();
    CCUADS_CmdVld = 1'b0;
    @(negedge clk);
    check("t2 refused push", AW'(ADSCCU_QCnt), AW'(4));
    tick();
    for (int k = 0; k < 5; k++) serveJob(k % 3, 1'b0);
    waitDone(6);
    @(negedge clk);
    check("t2 DoneCnt", AW'(ADSCCU_DoneCnt), AW'(6));
    tick();

    // 3: a Num=0 job completes one cycle after its pop and is never issued.
    pushJob(mkJob(20, 0));
    @(negedge clk);
    check("t3 queued", AW'(ADSCCU_QCnt), AW'(1));
    check("t3 no early done", AW'(ADSCCU_JobDone), AW'(0));
    tick();
    @(negedge clk);
    check("t3 popped", AW'(ADSCCU_QCnt), AW'(0));
    check("t3 done after pop", AW'(ADSCCU_JobDone), AW'(1));
    tick();
    base = issueSeen;
    ADDADS_CfgRdy = 1'b0;
    pushJob(mkJob(21, 2));
    pushJob(mkJob(22, 0));
    pushJob(mkJob(23, 2));
    serveJob(0, 1'b0);
    serveJob(1, 1'b0);
    waitDone(10);
    @(negedge clk);
    check("t3 issues", AW'(issueSeen - base), AW'(2));
    check("t3 DoneCnt", AW'(ADSCCU_DoneCnt), AW'(10));
    tick();

    // 4: flush in RUN with ADD busy gives one abort pulse and drops the queue and a same-cycle push.
    ADDADS_CfgRdy = 1'b0;
    pushJob(mkJob(30, 4));
    pushJob(mkJob(31, 2));
    waitIssue();
    tick();
    ADDADS_CfgRdy = 1'b0;
    oneWrite();
    CCUADS_Flush = 1'b1;
    CCUADS_CmdVld = 1'b1;
    CCUADS_CmdInfo = mkJob(32, 1);
    @(negedge clk);
    check("t4 no vld in RUN", AW'(ADSADD_CfgVld), AW'(0));
    tick();
    CCUADS_Flush = 1'b0;
    CCUADS_CmdVld = 1'b0;
    clearScoreboard();
    @(negedge clk);
    check("t4 abort pulse", AW'(ADSADD_CfgVld), AW'(1));
    check("t4 QCnt flushed", AW'(ADSCCU_QCnt), AW'(0));
    check("t4 DoneCnt cleared", AW'(ADSCCU_DoneCnt), AW'(0));
    check("t4 busy in abort", AW'(ADSCCU_Busy), AW'(1));
    tick();
    @(negedge clk);
    check("t4 pulse ends", AW'(ADSADD_CfgVld), AW'(0));
    check("t4 idle", AW'(ADSCCU_Busy), AW'(0));
    tick();
    ADDADS_CfgRdy = 1'b1;
    tick();

    // 5: flush in DRAIN with ADD idle gives no pulse and no JobDone.
    ADDADS_CfgRdy = 1'b0;
    pushJob(mkJob(40, 1));
    waitIssue();
    tick();
    ADDADS_CfgRdy = 1'b0;
    oneWrite();
    tick();
    ADDADS_CfgRdy = 1'b1;
    CCUADS_Flush = 1'b1;
    @(negedge clk);
    check("t5 busy in drain", AW'(ADSCCU_Busy), AW'(1));
    tick();
    CCUADS_Flush = 1'b0;
    clearScoreboard();
    @(negedge clk);
    check("t5 no abort pulse", AW'(ADSADD_CfgVld), AW'(0));
    check("t5 no done", AW'(ADSCCU_JobDone), AW'(0));
    tick();
    @(negedge clk);
    check("t5 idle", AW'(ADSCCU_Busy), AW'(0));
    check("t5 still no done", AW'(ADSCCU_JobDone), AW'(0));
    tick();

    // 6: reset mid-RUN returns every output to its reset value.
    ADDADS_CfgRdy = 1'b0;
    pushJob(mkJob(50, 3));
    pushJob(mkJob(51, 1));
    waitIssue();
    tick();
    ADDADS_CfgRdy = 1'b0;
    oneWrite();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clearScoreboard();
    @(negedge clk);
    check("t6 CmdRdy", AW'(ADSCCU_CmdRdy), AW'(1));
    check("t6 QCnt", AW'(ADSCCU_QCnt), AW'(0));
    check("t6 CfgVld", AW'(ADSADD_CfgVld), AW'(0));
    check("t6 CfgInfo", ADSADD_CfgInfo, AW'(0));
    check("t6 JobDone", AW'(ADSCCU_JobDone), AW'(0));
    check("t6 DoneCnt", AW'(ADSCCU_DoneCnt), AW'(0));
    check("t6 Busy", AW'(ADSCCU_Busy), AW'(0));
    tick();
    base = doneSeen;
    pushJob(mkJob(60, 1));
    serveJob(1, 1'b0);
    waitDone(base + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
